// File: rtl/dmem_port_arbiter.sv
// Single-port data SRAM arbiter: posted in-order write buffer, reads prioritised over drains.
// Define DMEM_ARB_FWD_EN to forward the youngest buffered store to a hitting read.
module dmem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int WBUF_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_gnt,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we_n,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  wbuf_full,
  output logic                  wbuf_empty
);
  localparam int PTR_W = $clog2(WBUF_DEPTH);
  localparam int CNT_W = $clog2(WBUF_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, RD, RSP, WR} state_t;
  state_t state_reg, state_next;

  logic [ADDR_WIDTH-1:0] buf_addr [WBUF_DEPTH];
  logic [DATA_WIDTH-1:0] buf_data [WBUF_DEPTH];
  logic [PTR_W-1:0]      head_reg, tail_reg;
  logic [CNT_W-1:0]      count_reg;
  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [DATA_WIDTH-1:0] head_data;

  logic                  rd_gnt_next;
  logic [DATA_WIDTH-1:0] rd_data_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [DATA_WIDTH-1:0] mem_wdata_next;
  logic                  mem_we_n_next;

  assign wbuf_full  = (count_reg == CNT_W'(WBUF_DEPTH));
  assign wbuf_empty = (count_reg == '0);
  assign wr_ack     = ~wbuf_full;
  assign push       = wr_req & ~wbuf_full;
  assign pop        = (state_reg == WR);
  assign head_addr  = buf_addr[head_reg];
  assign head_data  = buf_data[head_reg];

  always_ff @(posedge clk) begin
    if (push) begin
      buf_addr[tail_reg] <= wr_addr;
      buf_data[tail_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push) tail_reg <= tail_reg + 1'b1;
      if (pop)  head_reg <= head_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // entry_match is ordered by age: bit 0 is the head (oldest store)
  logic [WBUF_DEPTH-1:0] entry_match;
  logic                  rd_hit;

  generate
    for (genvar gi = 0; gi < WBUF_DEPTH; gi++) begin : g_match
      logic [PTR_W-1:0] idx;
      assign idx             = head_reg + PTR_W'(gi);
      assign entry_match[gi] = (CNT_W'(gi) < count_reg) && (buf_addr[idx] == rd_addr);
    end
  endgenerate

  assign rd_hit = |entry_match;

`ifdef DMEM_ARB_FWD_EN
  logic [DATA_WIDTH-1:0] fwd_data;

  // Later (younger) matches overwrite earlier ones
  always_comb begin
    fwd_data = '0;
    for (int i = 0; i < WBUF_DEPTH; i++) begin
      if (entry_match[i]) fwd_data = buf_data[head_reg + PTR_W'(i)];
    end
  end
`endif

  always_comb begin
    state_next     = state_reg;
    rd_gnt_next    = 1'b0;
    rd_data_next   = rd_data;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    mem_we_n_next  = 1'b1;
    case (state_reg)
      IDLE: begin
        if (wbuf_full) begin
          state_next     = WR;
          mem_addr_next  = head_addr;
          mem_wdata_next = head_data;
          mem_we_n_next  = 1'b0;
        end
`ifdef DMEM_ARB_FWD_EN
        else if (rd_req && rd_hit) begin
          state_next   = RSP;
          rd_data_next = fwd_data;
          rd_gnt_next  = 1'b1;
        end else if (rd_req) begin
          state_next    = RD;
          mem_addr_next = rd_addr;
        end
`else
        else if (rd_req && !rd_hit) begin
          state_next    = RD;
          mem_addr_next = rd_addr;
        end
`endif
        else if (!wbuf_empty) begin
          state_next     = WR;
          mem_addr_next  = head_addr;
          mem_wdata_next = head_data;
          mem_we_n_next  = 1'b0;
        end
      end
      RD: begin
        state_next   = RSP;
        rd_data_next = mem_rdata;
        rd_gnt_next  = 1'b1;
      end
      RSP:     state_next = IDLE;
      WR:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      rd_gnt    <= 1'b0;
      rd_data   <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we_n  <= 1'b1;
    end else begin
      state_reg <= state_next;
      rd_gnt    <= rd_gnt_next;
      rd_data   <= rd_data_next;
      mem_addr  <= mem_addr_next;
      mem_wdata <= mem_wdata_next;
      mem_we_n  <= mem_we_n_next;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed hazard cases, then random traffic checked against
// a logical memory (value at read request) and an in-order store queue.
module tb_dmem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic [DW-1:0] rd_data;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we_n;
  logic [DW-1:0] mem_rdata;
  logic          wbuf_full;
  logic          wbuf_empty;

  always #5 clk = ~clk;

  dmem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WBUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we_n(mem_we_n), .mem_rdata(mem_rdata),
    .wbuf_full(wbuf_full), .wbuf_empty(wbuf_empty)
  );

  // SRAM: async read, write on the rising edge while mem_we_n is low; pl_* preloads a word
  logic [DW-1:0] sram [256] = '{default: '0};
  logic          pl_en = 1'b0;
  logic [7:0]    pl_addr = '0;
  logic [DW-1:0] pl_data = '0;

  assign mem_rdata = sram[mem_addr[7:0]];

  always @(posedge clk) begin
    if (!mem_we_n) sram[mem_addr[7:0]] <= mem_wdata;
    if (pl_en) sram[pl_addr] <= pl_data;
  end

  int tests = 0;
  int fails = 0;
  logic [DW-1:0]    model_mem [256];
  logic [AW+DW-1:0] wq [$];
  bit               rd_pending;
  logic [DW-1:0]    rd_exp;
  int               rd_wait;
  bit               last_gnt;
  int               wr_seen;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // One clock: commit the store accepted at this edge, then check flags, SRAM writes and reads
  task automatic step();
    bit pushed;
    logic [AW+DW-1:0] exp_wr;
    pushed = wr_req && wr_ack;
    @(negedge clk);
    if (pushed) begin
      model_mem[wr_addr[7:0]] = wr_data;
      wq.push_back({wr_addr, wr_data});
    end
    check("wbuf_empty", 32'(wbuf_empty), 32'(wq.size() == 0));
    check("wbuf_full", 32'(wbuf_full), 32'(wq.size() == DEPTH));
    check("wr_ack", 32'(wr_ack), 32'(wq.size() != DEPTH));
    if (!mem_we_n) begin
      wr_seen++;
      exp_wr = (wq.size() != 0) ? wq[0] : ~{mem_addr, mem_wdata};
      check("wr_order", {mem_addr, mem_wdata}, exp_wr);
      if (wq.size() != 0) void'(wq.pop_front());
    end
    last_gnt = rd_gnt;
    if (!rd_pending) begin
      check("rd_gnt_idle", 32'(rd_gnt), 32'd0);
    end else if (rd_gnt) begin
      check("rd_data", 32'(rd_data), 32'(rd_exp));
      rd_pending = 1'b0;
      rd_req = 1'b0;
    end else begin
      rd_wait++;
      if (rd_wait > 64) begin
        check("rd_timeout", 32'(rd_wait), 32'd64);
        rd_pending = 1'b0;
        rd_req = 1'b0;
      end
    end
  endtask

  task automatic start_read(input logic [AW-1:0] a);
    rd_req = 1'b1;
    rd_addr = a;
    rd_pending = 1'b1;
    rd_exp = model_mem[a[7:0]];
    rd_wait = 0;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_req = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic preload(input logic [7:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1;
    pl_addr = a;
    pl_data = d;
    model_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  task automatic wait_gnt(input int bound, output int n);
    n = 0;
    last_gnt = 1'b0;
    while (!last_gnt && n < bound) begin
      step();
      n++;
    end
    if (!last_gnt) check("gnt_timeout", 32'(n), 32'(bound + 1));
  endtask

  task automatic drain();
    int n;
    n = 0;
    wr_req = 1'b0;
    while ((rd_pending || !wbuf_empty || !mem_we_n) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) check("drain_timeout", 32'(n), 32'd0);
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    int w0;
    logic [AW-1:0] ra;
    reset_n = 1'b0;
    rd_req = 1'b0;
    rd_addr = '0;
    wr_req = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_pending = 1'b0;
    rd_exp = '0;
    rd_wait = 0;
    last_gnt = 1'b0;
    wr_seen = 0;
    for (int i = 0; i < 256; i++) model_mem[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_rd_gnt", 32'(rd_gnt), 32'd0);
    check("rst_rd_data", 32'(rd_data), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_mem_we_n", 32'(mem_we_n), 32'd1);
    check("rst_empty", 32'(wbuf_empty), 32'd1);
    check("rst_full", 32'(wbuf_full), 32'd0);
    check("rst_wr_ack", 32'(wr_ack), 32'd1);
    reset_n = 1'b1;
    step();

    // plain read: grant two edges after the request is sampled
    preload(8'h10, 16'h1234);
    start_read(16'h0010);
    step();
    check("t1_gnt_early", 32'(rd_gnt), 32'd0);
    check("t1_we_n_a", 32'(mem_we_n), 32'd1);
    step();
    check("t1_gnt", 32'(rd_gnt), 32'd1);
    check("t1_data", 32'(rd_data), 32'h1234);
    check("t1_we_n_b", 32'(mem_we_n), 32'd1);
    step();
    $display("[TB] t1 read 0x0010 -> %h", rd_data);

    // posted store drains on the following cycle
    drive_wr(16'h0020, 16'hBEEF);
    check("t2_wr_ack", 32'(wr_ack), 32'd1);
    step();
    wr_req = 1'b0;
    check("t2_we_n_idle", 32'(mem_we_n), 32'd1);
    step();
    check("t2_we_n", 32'(mem_we_n), 32'd0);
    check("t2_addr", 32'(mem_addr), 32'h0020);
    check("t2_wdata", 32'(mem_wdata), 32'hBEEF);
    step();
    check("t2_we_n_after", 32'(mem_we_n), 32'd1);
    check("t2_empty", 32'(wbuf_empty), 32'd1);
    check("t2_sram", 32'(sram[8'h20]), 32'hBEEF);
    $display("[TB] t2 store 0x0020 <= BEEF, sram=%h", sram[8'h20]);

    // two buffered stores to one address, then a read of it
    start_read(16'h0031);
    drive_wr(16'h0030, 16'h1111);
    step();
    drive_wr(16'h0030, 16'h2222);
    step();
    wr_req = 1'b0;
    check("t3_gnt_31", 32'(last_gnt), 32'd1);
    start_read(16'h0030);
    w0 = wr_seen;
    wait_gnt(20, n);
    check("t3_data", 32'(rd_data), 32'h2222);
`ifdef DMEM_ARB_FWD_EN
    check("t3_latency", 32'(n), 32'd2);
    check("t3_no_sram_wr", 32'(wr_seen - w0), 32'd0);
`else
    check("t3_latency", 32'(n), 32'd7);
    check("t3_drained", 32'(wr_seen - w0), 32'd2);
`endif
    $display("[TB] t3 read 0x0030 -> %h after %0d edges", rd_data, n);
    drain();

    // back-to-back reads starve the drain until the buffer fills
    start_read(16'h0041);
    drive_wr(16'h0060, 16'hA000);
    step();
    drive_wr(16'h0061, 16'hA001);
    step();
    start_read(16'h0042);
    drive_wr(16'h0062, 16'hA002);
    step();
    drive_wr(16'h0063, 16'hA003);
    step();
    wr_req = 1'b0;
    check("t4_full", 32'(wbuf_full), 32'd1);
    check("t4_wr_ack", 32'(wr_ack), 32'd0);
    step();
    start_read(16'h0040);
    w0 = wr_seen;
    wait_gnt(20, n);
    check("t4_latency", 32'(n), 32'd5);
    check("t4_one_drain", 32'(wr_seen - w0), 32'd1);
    check("t4_wr_ack_back", 32'(wr_ack), 32'd1);
    $display("[TB] t4 read 0x0040 granted after %0d edges, %0d drain(s)", n, wr_seen - w0);
    drain();

    // store at the same edge as the read is ordered after it
    preload(8'h50, 16'h0007);
    start_read(16'h0050);
    drive_wr(16'h0050, 16'h0009);
    step();
    wr_req = 1'b0;
    wait_gnt(20, n);
    check("t5_old_value", 32'(rd_data), 32'h0007);
    drain();
    check("t5_sram", 32'(sram[8'h50]), 32'h0009);
    $display("[TB] t5 read 0x0050 -> %h, sram=%h", rd_data, sram[8'h50]);

    // reset in the middle of a write cycle
    drive_wr(16'h0070, 16'h7070);
    step();
    drive_wr(16'h0071, 16'h7171);
    step();
    wr_req = 1'b0;
    check("t6_in_wr", 32'(mem_we_n), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t6_we_n_async", 32'(mem_we_n), 32'd1);
    check("t6_empty", 32'(wbuf_empty), 32'd1);
    check("t6_full", 32'(wbuf_full), 32'd0);
    check("t6_rd_gnt", 32'(rd_gnt), 32'd0);
    wq.delete();
    model_mem[8'h70] = '0;
    model_mem[8'h71] = '0;
    step();
    step();
    reset_n = 1'b1;
    repeat (6) step();
    check("t6_sram70", 32'(sram[8'h70]), 32'd0);
    check("t6_sram71", 32'(sram[8'h71]), 32'd0);
    $display("[TB] t6 reset mid-write, sram70=%h sram71=%h", sram[8'h70], sram[8'h71]);

    // random mixed traffic over a small address window so hits are frequent
    for (int c = 0; c < 3000; c++) begin
      if (!rd_pending && $urandom_range(2) == 0) start_read(AW'($urandom_range(15)));
      if ($urandom_range(1) == 0) begin
        ra = AW'($urandom_range(15));
        if (rd_pending && ra == rd_addr) ra = ra ^ 16'h0001;
        drive_wr(ra, DW'($urandom));
      end else begin
        wr_req = 1'b0;
      end
      step();
    end
    drain();
    for (int i = 0; i < 256; i++) check("sram_final", 32'(sram[i]), 32'(model_mem[i]));
    $display("[TB] random phase done, %0d SRAM writes observed", wr_seen);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
